// File: rtl/alu_op_sequencer.sv
// ALU operation decoder/sequencer: turns ALUOp/funct into a registered ALU code
// and holds the pipeline (busy) for the duration of multi-cycle mult/div.
module alu_op_sequencer #(
  parameter int OP_W       = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      ALUOp,
  input  logic [5:0]      funct,
  input  logic            flush,
  output logic [OP_W-1:0] operation,
  output logic            out_valid,
  output logic            Jr,
  output logic            hilo_we,
  output logic            busy,
  output logic            illegal
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic       jr;
    logic       illegal;
    logic       multi;
    logic       div;
  } dec_t;

  function automatic dec_t decode(input logic [2:0] aluop, input logic [5:0] fn);
    dec_t d;
    d    = '0;
    d.op = 4'b0010;
    case (aluop)
      3'b000: d.op = 4'b0010;
      3'b001: d.op = 4'b0110;
      3'b100: d.op = 4'b0000;
      3'b101: d.op = 4'b0001;
      3'b010: begin
        case (fn)
          6'b100000: d.op = 4'b0010;
          6'b100010: d.op = 4'b0110;
          6'b100100: d.op = 4'b0000;
          6'b100101: d.op = 4'b0001;
          6'b101010: d.op = 4'b0111;
          6'b000000: d.op = 4'b0101;
          6'b100111: d.op = 4'b1011;
          6'b001000: d.jr = 1'b1;
          6'b011000: begin
            d.op    = 4'b1000;
            d.multi = 1'b1;
          end
          6'b011010: begin
            d.op    = 4'b1001;
            d.multi = 1'b1;
            d.div   = 1'b1;
          end
          default:   d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  dec_t             dec;
  logic             accept;

  always_comb begin
    dec = decode(ALUOp, funct);
  end

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready && !flush;

  // Result flags are single-cycle pulses; operation is held between results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      operation <= '0;
      out_valid <= 1'b0;
      Jr        <= 1'b0;
      hilo_we   <= 1'b0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      Jr        <= 1'b0;
      hilo_we   <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            operation <= OP_W'(dec.op);
            if (dec.multi) begin
              state <= BUSY;
              busy  <= 1'b1;
              cnt   <= dec.div ? DIV_LOAD : MUL_LOAD;
            end else begin
              out_valid <= 1'b1;
              Jr        <= dec.jr;
              illegal   <= dec.illegal;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt <= CNT_ONE) begin
            // Last busy cycle: counter lands on 0 as the result is presented.
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b1;
            hilo_we   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a cycle-level reference model and
// hand-computed spot checks; a second instance covers the OP_W=6 build.
module tb_alu_op_sequencer;

  localparam int MUL_N = 4;
  localparam int DIV_N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] ALUOp = 3'b000;
  logic [5:0] funct = 6'b000000;

  logic       in_ready, out_valid, Jr, hilo_we, busy, illegal;
  logic [3:0] operation;
  logic       in_ready6, out_valid6, Jr6, hilo_we6, busy6, illegal6;
  logic [5:0] operation6;

  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct(funct), .flush(flush), .operation(operation),
    .out_valid(out_valid), .Jr(Jr), .hilo_we(hilo_we), .busy(busy), .illegal(illegal)
  );

  alu_op_sequencer #(.OP_W(6)) dut6 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready6),
    .ALUOp(ALUOp), .funct(funct), .flush(flush), .operation(operation6),
    .out_valid(out_valid6), .Jr(Jr6), .hilo_we(hilo_we6), .busy(busy6), .illegal(illegal6)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result timing by absolute cycle number of completion.
  int         cyc = 0;
  int         due = -1;
  logic [3:0] e_op = 4'b0000;
  logic       e_ov = 1'b0, e_jr = 1'b0, e_hw = 1'b0, e_il = 1'b0, e_busy = 1'b0;
  logic [3:0] m_op;
  logic       m_jr, m_il;
  int         m_lat;

  task automatic ref_decode(input logic [2:0] a, input logic [5:0] f,
                            output logic [3:0] op, output logic jr,
                            output logic il, output int lat);
    op = 4'b0010; jr = 1'b0; il = 1'b0; lat = 0;
    case (a)
      3'b000: op = 4'b0010;
      3'b001: op = 4'b0110;
      3'b100: op = 4'b0000;
      3'b101: op = 4'b0001;
      3'b010: begin
        case (f)
          6'b100000: op = 4'b0010;
          6'b100010: op = 4'b0110;
          6'b100100: op = 4'b0000;
          6'b100101: op = 4'b0001;
          6'b101010: op = 4'b0111;
          6'b000000: op = 4'b0101;
          6'b100111: op = 4'b1011;
          6'b001000: jr = 1'b1;
          6'b011000: begin op = 4'b1000; lat = MUL_N; end
          6'b011010: begin op = 4'b1001; lat = DIV_N; end
          default:   il = 1'b1;
        endcase
      end
      default: il = 1'b1;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      due = -1; e_op = 4'b0000; e_ov = 1'b0; e_jr = 1'b0; e_hw = 1'b0;
      e_il = 1'b0; e_busy = 1'b0;
    end else begin
      e_ov = 1'b0; e_jr = 1'b0; e_hw = 1'b0; e_il = 1'b0;
      if (due >= 0) begin
        if (flush) due = -1;
      end else if (in_valid && !flush) begin
        ref_decode(ALUOp, funct, m_op, m_jr, m_il, m_lat);
        e_op = m_op;
        if (m_lat == 0) begin
          e_ov = 1'b1; e_jr = m_jr; e_il = m_il;
        end else begin
          due = cyc + m_lat;
        end
      end
      if (due >= 0 && cyc + 1 == due) begin
        e_ov = 1'b1; e_hw = 1'b1; due = -1;
      end
      e_busy = (due >= 0);
      cyc = cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("operation",    8'(operation),  8'(e_op));
      chk("out_valid",    8'(out_valid),  8'(e_ov));
      chk("Jr",           8'(Jr),         8'(e_jr));
      chk("hilo_we",      8'(hilo_we),    8'(e_hw));
      chk("illegal",      8'(illegal),    8'(e_il));
      chk("busy",         8'(busy),       8'(e_busy));
      chk("in_ready",     8'(in_ready),   8'(!e_busy));
      chk("operation_w6", 8'(operation6), 8'(e_op));
      chk("out_valid_w6", 8'(out_valid6), 8'(e_ov));
      chk("hilo_we_w6",   8'(hilo_we6),   8'(e_hw));
      chk("busy_w6",      8'(busy6),      8'(e_busy));
      chk("in_ready_w6",  8'(in_ready6),  8'(!e_busy));
      chk("Jr_w6",        8'(Jr6),        8'(e_jr));
      chk("illegal_w6",   8'(illegal6),   8'(e_il));
    end
  end

  // Inputs for one cycle are applied just after a falling edge; returns in the next cycle.
  task automatic cyc_in(input logic v, input logic [2:0] a, input logic [5:0] f, input logic fl);
    in_valid = v; ALUOp = a; funct = f; flush = fl;
    @(negedge clk);
    #1;
  endtask

  logic [2:0] a_tab [12] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b001,
                             3'b100, 3'b101, 3'b011, 3'b110, 3'b010, 3'b010};
  logic [5:0] f_tab [12] = '{6'b100100, 6'b100101, 6'b000000, 6'b100111, 6'b100000, 6'b100000,
                             6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b111111, 6'b000001};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_operation", 8'(operation), 8'h00);
    chk("rst_in_ready",  8'(in_ready),  8'h01);
    chk("rst_busy",      8'(busy),      8'h00);
    chk("rst_out_valid", 8'(out_valid), 8'h00);
    #1 reset = 1'b0;

    // Back-to-back single-cycle add/sub/slt
    cyc_in(1'b1, 3'b010, 6'b100000, 1'b0);
    chk("b2b_add_op", 8'(operation), 8'h02);
    chk("b2b_add_ov", 8'(out_valid), 8'h01);
    cyc_in(1'b1, 3'b010, 6'b100010, 1'b0);
    chk("b2b_sub_op", 8'(operation), 8'h06);
    cyc_in(1'b1, 3'b010, 6'b101010, 1'b0);
    chk("b2b_slt_op", 8'(operation), 8'h07);
    chk("b2b_busy",   8'(busy),      8'h00);
    cyc_in(1'b0, 3'b000, 6'b000000, 1'b0);
    chk("b2b_idle_ov", 8'(out_valid), 8'h00);

    for (int i = 0; i < 12; i++) cyc_in(1'b1, a_tab[i], f_tab[i], 1'b0);
    cyc_in(1'b0, 3'b000, 6'b000000, 1'b0);

    // jr and illegal pulses
    cyc_in(1'b1, 3'b010, 6'b001000, 1'b0);
    chk("jr_flag", 8'(Jr), 8'h01);
    chk("jr_op",   8'(operation), 8'h02);
    cyc_in(1'b1, 3'b111, 6'b100000, 1'b0);
    chk("jr_pulse", 8'(Jr), 8'h00);
    chk("ill_flag", 8'(illegal), 8'h01);
    chk("ill_op",   8'(operation), 8'h02);
    cyc_in(1'b0, 3'b000, 6'b000000, 1'b0);
    chk("ill_pulse", 8'(illegal), 8'h00);

    // mult with a request held during BUSY
    cyc_in(1'b1, 3'b010, 6'b011000, 1'b0);
    chk("mul_busy1",  8'(busy),     8'h01);
    chk("mul_ready1", 8'(in_ready), 8'h00);
    cyc_in(1'b1, 3'b010, 6'b100000, 1'b0);
    cyc_in(1'b1, 3'b010, 6'b100000, 1'b0);
    chk("mul_busy3", 8'(busy), 8'h01);
    cyc_in(1'b0, 3'b000, 6'b000000, 1'b0);
    chk("mul_ov",    8'(out_valid), 8'h01);
    chk("mul_hw",    8'(hilo_we),   8'h01);
    chk("mul_op",    8'(operation), 8'h08);
    chk("mul_ready", 8'(in_ready),  8'h01);
    chk("mul_op_w6", 8'(operation6), 8'h08);
    cyc_in(1'b0, 3'b000, 6'b000000, 1'b0);

    // div full latency
    cyc_in(1'b1, 3'b010, 6'b011010, 1'b0);
    repeat (6) cyc_in(1'b0, 3'b000, 6'b000000, 1'b0);
    chk("div_busy7", 8'(busy), 8'h01);
    chk("div_ov7",   8'(out_valid), 8'h00);
    cyc_in(1'b0, 3'b000, 6'b000000, 1'b0);
    chk("div_ov8", 8'(out_valid), 8'h01);
    chk("div_op",  8'(operation), 8'h09);

    // flush mid-div at t+3, add at t+4
    cyc_in(1'b1, 3'b010, 6'b011010, 1'b0);
    cyc_in(1'b0, 3'b000, 6'b000000, 1'b0);
    cyc_in(1'b0, 3'b000, 6'b000000, 1'b0);
    cyc_in(1'b0, 3'b000, 6'b000000, 1'b1);
    chk("flush_busy",  8'(busy),     8'h00);
    chk("flush_ready", 8'(in_ready), 8'h01);
    cyc_in(1'b1, 3'b010, 6'b100000, 1'b0);
    chk("flush_add_ov", 8'(out_valid), 8'h01);
    chk("flush_add_hw", 8'(hilo_we),   8'h00);
    chk("flush_add_op", 8'(operation), 8'h02);
    repeat (6) cyc_in(1'b0, 3'b000, 6'b000000, 1'b0);

    // flush colliding with a request, then flush while idle
    cyc_in(1'b1, 3'b010, 6'b100010, 1'b1);
    chk("flush_req_ov", 8'(out_valid), 8'h00);
    cyc_in(1'b0, 3'b000, 6'b000000, 1'b1);
    cyc_in(1'b1, 3'b010, 6'b011000, 1'b1);
    chk("flush_mul_busy", 8'(busy), 8'h00);

    // async reset pulse mid-mult
    cyc_in(1'b1, 3'b010, 6'b011000, 1'b0);
    chk("rst_mid_busy_pre", 8'(busy), 8'h01);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_busy",  8'(busy),      8'h00);
    chk("rst_mid_ready", 8'(in_ready),  8'h01);
    chk("rst_mid_op",    8'(operation), 8'h00);
    #1 reset = 1'b0;
    cyc_in(1'b1, 3'b010, 6'b100101, 1'b0);
    chk("post_rst_ov", 8'(out_valid), 8'h01);
    chk("post_rst_op", 8'(operation), 8'h01);
    repeat (5) cyc_in(1'b0, 3'b000, 6'b000000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
